// File: rtl/axi_slave_wr_resp_pkg.sv
// Shared AXI write-responder definitions: FSM encodings, BRESP/AWBURST codes, default widths.
package axi_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    DATA = ST_DATA,
    RESP = ST_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam int DEF_ID_W   = 8;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 4;

endpackage

// File: rtl/axi_slave_wr_resp_if.sv
// AW/W/B channel bundle between interconnect (master side) and one memory slave responder.
interface axi_slave_wr_resp_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) ();

  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [LEN_W-1:0]    AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

endinterface

// File: rtl/axi_slave_wr_resp_addr_gen.sv
// Burst address generator: current byte address and beat counter for one write burst.
module axi_wr_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 4,
  parameter int BEAT_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        burst,
  input  logic              step,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              last_beat
);

  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  beat_cnt;
  logic [LEN_W-1:0]  len_q;
  logic [1:0]        burst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      burst_q  <= BURST_FIXED;
    end else if (load) begin
      cur_addr <= start_addr;
      beat_cnt <= '0;
      len_q    <= len;
      burst_q  <= burst;
    end else if (step) begin
      beat_cnt <= beat_cnt + 1'b1;
      // Anything other than FIXED (incl. reserved codes) advances like INCR; wraps at 2^ADDR_W.
      if (burst_q != BURST_FIXED)
        cur_addr <= cur_addr + ADDR_W'(BEAT_BYTES);
    end
  end

  assign mem_addr  = cur_addr[ADDR_W-1:2];
  assign last_beat = (beat_cnt == len_q);

endmodule

// File: rtl/axi_slave_wr_resp.sv
// AXI slave write responder: one AW burst, W beats to SRAM strobes, then B response.
// Optional macro AXI_WLAST_CHECK_EN: a WLAST/AWLEN mismatch ends the burst and yields SLVERR.
module axi_slave_wr_resp
  import axi_pkg::*;
#(
  parameter int ID_W   = DEF_ID_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_slave_wr_resp_if.slave   axi,
  output logic [DATA_W/8-1:0]  mem_web,
  output logic [ADDR_W-3:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata
);

  localparam int         BEAT_BYTES = DATA_W / 8;
  localparam logic [2:0] SIZE_CODE  = 3'($clog2(BEAT_BYTES));

  state_t          state;
  logic [ID_W-1:0] id_q;
  logic            err;
  logic            aw_hs;
  logic            w_hs;
  logic            last_beat;
  logic            burst_done;
  logic            wlast_err;

  assign aw_hs = (state == IDLE) && !rst && axi.AWVALID;
  assign w_hs  = (state == DATA) && axi.WVALID;

`ifdef AXI_WLAST_CHECK_EN
  assign wlast_err  = (axi.WLAST != last_beat);
  assign burst_done = last_beat || axi.WLAST;
`else
  logic wlast_unused;
  assign wlast_unused = axi.WLAST;
  assign wlast_err    = 1'b0;
  assign burst_done   = last_beat;
`endif

  axi_wr_addr_gen #(
    .ADDR_W     (ADDR_W),
    .LEN_W      (LEN_W),
    .BEAT_BYTES (BEAT_BYTES)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (aw_hs),
    .start_addr (axi.AWADDR),
    .len        (axi.AWLEN),
    .burst      (axi.AWBURST),
    .step       (w_hs),
    .mem_addr   (mem_addr),
    .last_beat  (last_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      id_q  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (aw_hs) begin
          id_q  <= axi.AWID;
          err   <= (axi.AWSIZE != SIZE_CODE);
          state <= DATA;
        end
        DATA: if (w_hs) begin
          // err is registered, so the beat that exposes a WLAST mismatch is still written.
          if (wlast_err)
            err <= 1'b1;
          if (burst_done)
            state <= RESP;
        end
        RESP: if (axi.BREADY)
          state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign axi.AWREADY = (state == IDLE) && !rst;
  assign axi.WREADY  = (state == DATA);
  assign axi.BVALID  = (state == RESP);
  assign axi.BID     = id_q;
  assign axi.BRESP   = err ? RESP_SLVERR : RESP_OKAY;

  assign mem_web   = (w_hs && !err) ? ~axi.WSTRB : '1;
  assign mem_wdata = axi.WDATA;

endmodule

// File: tb/tb_axi_slave_wr_resp.sv
// Scoreboard bench for axi_slave_wr_resp: stimulus queues expected writes/B responses, a monitor pops them.
module tb_axi_slave_wr_resp;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_slave_wr_resp_if #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) bus ();

  logic [3:0]  mem_web;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;

  axi_slave_wr_resp #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (bus),
    .mem_web   (mem_web),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  web;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } b_t;

  wr_t wq[$];
  b_t  bq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe and every B handshake must match the head of its queue.
  initial begin
    wr_t ew;
    b_t  eb;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_web !== 4'hF) begin
          if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write actual=addr %0h web %0h required=none", mem_addr, mem_web);
          end else begin
            ew = wq.pop_front();
            chk("wr_addr", 64'(mem_addr), 64'(ew.addr));
            chk("wr_web", 64'(mem_web), 64'(ew.web));
            chk("wr_data", 64'(mem_wdata), 64'(ew.data));
          end
        end
        if (bus.BVALID && bus.BREADY) begin
          if (bq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_b actual=id %0h resp %0h required=none", bus.BID, bus.BRESP);
          end else begin
            eb = bq.pop_front();
            chk("b_id", 64'(bus.BID), 64'(eb.id));
            chk("b_resp", 64'(bus.BRESP), 64'(eb.resp));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst;
    bus.AWVALID = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.AWREADY && n < 20);
    if (!bus.AWREADY) begin
      checks++; errors++;
      $display("FAIL aw_timeout actual=AWREADY 0 required=1");
    end
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                        input int gap, input bit wr, input logic [29:0] addr);
    int n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    if (wr) wq.push_back('{addr: addr, web: ~strb, data: data});
    bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.WREADY && n < 20);
    if (!bus.WREADY) begin
      checks++; errors++;
      $display("FAIL w_timeout actual=WREADY 0 required=1");
    end
    @(posedge clk); #1;
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
  endtask

  initial begin
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = 3'd2; bus.AWBURST = BURST_INCR;
    bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 64'(bus.AWREADY), 64'd0);
    chk("rst_wready", 64'(bus.WREADY), 64'd0);
    chk("rst_bvalid", 64'(bus.BVALID), 64'd0);
    chk("rst_bid", 64'(bus.BID), 64'd0);
    chk("rst_bresp", 64'(bus.BRESP), 64'd0);
    chk("rst_web", 64'(mem_web), 64'hF);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("awready_after_rst", 64'(bus.AWREADY), 64'd1);
    @(posedge clk); #1;

    // Single beat
    bq.push_back('{id: 8'h15, resp: RESP_OKAY});
    aw(8'h15, 32'h0000_0100, 4'd0, 3'd2, BURST_INCR);
    w_beat(32'hDEAD_BEEF, 4'hF, 1'b1, 0, 1'b1, 30'h40);
    chk("bvalid_latency", 64'(bus.BVALID), 64'd1);

    // INCR burst across 4 KiB, WVALID every other cycle
    bq.push_back('{id: 8'h22, resp: RESP_OKAY});
    aw(8'h22, 32'h0000_0FF8, 4'd3, 3'd2, BURST_INCR);
    w_beat(32'h1111_0001, 4'hF, 1'b0, 1, 1'b1, 30'h3FE);
    w_beat(32'h2222_0002, 4'h3, 1'b0, 1, 1'b1, 30'h3FF);
    w_beat(32'h3333_0003, 4'hC, 1'b0, 1, 1'b1, 30'h400);
    chk("bvalid_before_last", 64'(bus.BVALID), 64'd0);
    w_beat(32'h4444_0004, 4'h1, 1'b1, 1, 1'b1, 30'h401);

    // FIXED burst
    bq.push_back('{id: 8'h33, resp: RESP_OKAY});
    aw(8'h33, 32'h0000_0200, 4'd2, 3'd2, BURST_FIXED);
    w_beat(32'hA000_0000, 4'hF, 1'b0, 0, 1'b1, 30'h80);
    w_beat(32'hA000_0001, 4'hF, 1'b0, 0, 1'b1, 30'h80);
    w_beat(32'hA000_0002, 4'hF, 1'b1, 0, 1'b1, 30'h80);

    // Address wrap
    bq.push_back('{id: 8'h44, resp: RESP_OKAY});
    aw(8'h44, 32'hFFFF_FFFC, 4'd1, 3'd2, BURST_INCR);
    w_beat(32'hB000_0000, 4'hF, 1'b0, 0, 1'b1, 30'h3FFF_FFFF);
    w_beat(32'hB000_0001, 4'hF, 1'b1, 0, 1'b1, 30'h0);

    // B backpressure with a pending AW
    bq.push_back('{id: 8'h55, resp: RESP_OKAY});
    aw(8'h55, 32'h0000_0000, 4'd0, 3'd2, BURST_INCR);
    bus.BREADY = 1'b0;
    w_beat(32'hC000_0000, 4'hF, 1'b1, 0, 1'b1, 30'h0);
    bus.AWID = 8'h56; bus.AWADDR = 32'h0000_0004; bus.AWLEN = 4'd0;
    bus.AWSIZE = 3'd2; bus.AWBURST = BURST_INCR; bus.AWVALID = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_bvalid", 64'(bus.BVALID), 64'd1);
      chk("stall_bid", 64'(bus.BID), 64'h55);
      chk("stall_bresp", 64'(bus.BRESP), 64'(RESP_OKAY));
      chk("stall_awready", 64'(bus.AWREADY), 64'd0);
    end
    @(posedge clk); #1;
    bus.BREADY = 1'b1;
    @(negedge clk);
    chk("awready_in_resp", 64'(bus.AWREADY), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("aw_first_idle", 64'(bus.AWREADY), 64'd1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    bq.push_back('{id: 8'h56, resp: RESP_OKAY});
    w_beat(32'hC000_0001, 4'hF, 1'b1, 0, 1'b1, 30'h1);

    // Bad AWSIZE: no writes, SLVERR
    bq.push_back('{id: 8'h66, resp: RESP_SLVERR});
    aw(8'h66, 32'h0000_0300, 4'd1, 3'd1, BURST_INCR);
    w_beat(32'hD000_0000, 4'hF, 1'b0, 0, 1'b0, 30'h0);
    w_beat(32'hD000_0001, 4'hF, 1'b1, 0, 1'b0, 30'h0);

    // Early WLAST on beat 2 of 4
`ifdef AXI_WLAST_CHECK_EN
    bq.push_back('{id: 8'h77, resp: RESP_SLVERR});
    aw(8'h77, 32'h0000_0400, 4'd3, 3'd2, BURST_INCR);
    w_beat(32'hE000_0000, 4'hF, 1'b0, 0, 1'b1, 30'h100);
    w_beat(32'hE000_0001, 4'hF, 1'b1, 0, 1'b1, 30'h101);
    chk("early_wlast_exit", 64'(bus.WREADY), 64'd0);
`else
    bq.push_back('{id: 8'h77, resp: RESP_OKAY});
    aw(8'h77, 32'h0000_0400, 4'd3, 3'd2, BURST_INCR);
    w_beat(32'hE000_0000, 4'hF, 1'b0, 0, 1'b1, 30'h100);
    w_beat(32'hE000_0001, 4'hF, 1'b1, 0, 1'b1, 30'h101);
    chk("wlast_ignored", 64'(bus.WREADY), 64'd1);
    w_beat(32'hE000_0002, 4'hF, 1'b0, 0, 1'b1, 30'h102);
    w_beat(32'hE000_0003, 4'hF, 1'b1, 0, 1'b1, 30'h103);
`endif

    // Reset mid-burst: two of four beats, then abort with no B
    aw(8'h88, 32'h0000_0500, 4'd3, 3'd2, BURST_INCR);
    w_beat(32'hF000_0000, 4'hF, 1'b0, 0, 1'b1, 30'h140);
    w_beat(32'hF000_0001, 4'hF, 1'b0, 0, 1'b1, 30'h141);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_awready", 64'(bus.AWREADY), 64'd0);
    chk("midrst_wready", 64'(bus.WREADY), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_awready", 64'(bus.AWREADY), 64'd1);
    chk("postrst_bvalid", 64'(bus.BVALID), 64'd0);
    chk("postrst_mem_addr", 64'(mem_addr), 64'd0);
    repeat (3) @(posedge clk);
    #1;

    // Recovery transaction
    bq.push_back('{id: 8'h99, resp: RESP_OKAY});
    aw(8'h99, 32'h0000_0008, 4'd0, 3'd2, BURST_INCR);
    w_beat(32'h0BAD_F00D, 4'h5, 1'b1, 0, 1'b1, 30'h2);

    repeat (5) @(posedge clk);
    #1;
    chk("wq_drained", 64'(wq.size()), 64'd0);
    chk("bq_drained", 64'(bq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_slave_wr_resp.md
Name: axi_slave_wr_resp

Overview:
- Slave-side AXI write responder: accepts one AW burst, absorbs its W beats, drives single-cycle SRAM write strobes, then returns the B response.
- Generates the BID_Sx/BRESP_Sx/BVALID_Sx stream that the interconnect's B-channel mux consumes; one instance per memory slave.
- One outstanding transaction only; no write interleaving.

Parameters:
- ID_W, 8, AW/B ID width (slave-side ID: master bits + master ID)
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; beat size fixed at DATA_W/8 bytes
- LEN_W, 4, AWLEN width (bursts of 1..16 beats)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- AWID  in  ID_W  write address ID
- AWADDR  in  ADDR_W  start byte address
- AWLEN  in  LEN_W  beats-1
- AWSIZE  in  3  beat size code
- AWBURST  in  2  00 FIXED, 01 INCR, 10/11 treated as INCR
- AWVALID  in  1  AW valid
- AWREADY  out  1  AW ready
- WDATA  in  DATA_W  write data
- WSTRB  in  DATA_W/8  byte strobes
- WLAST  in  1  last beat
- WVALID  in  1  W valid
- WREADY  out  1  W ready
- BID  out  ID_W  response ID
- BRESP  out  2  00 OKAY, 10 SLVERR
- BVALID  out  1  B valid
- BREADY  in  1  B ready
- mem_web  out  DATA_W/8  per-byte write enable, active-low
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  DATA_W  write data

Behaviour:
- FSM states IDLE, DATA, RESP. Reset: state IDLE; AWREADY=0 during reset, 1 in the first IDLE cycle after it; WREADY=0, BVALID=0, BID=0, BRESP=00, mem_web all 1, mem_addr=0, internal counters 0.
- IDLE: AWREADY=1, WREADY=0. On AWVALID&AWREADY: latch AWID, AWADDR, AWLEN, AWBURST; clear beat count; err = (AWSIZE != log2(DATA_W/8)); go to DATA next cycle.
- DATA: AWREADY=0, WREADY=1. mem_web = ~WSTRB when WVALID&WREADY, else all 1. mem_addr = cur_addr[ADDR_W-1:2]. mem_wdata = WDATA, combinational, same cycle as the handshake. If err is set, mem_web is held all 1 (no write).
- Each W handshake: beat count +1. INCR adds DATA_W/8 to cur_addr, wrapping modulo 2^ADDR_W. FIXED holds cur_addr.
- DATA exits when beat count == latched AWLEN on a handshake. Go to RESP next cycle.
- RESP: BVALID=1, BID=latched ID, BRESP = err ? 10 : 00. BID and BRESP stay stable while BVALID=1. On BVALID&BREADY go to IDLE; the next AW is accepted one cycle later at the earliest.
- Latency: AW handshake at cycle 0; earliest W beat at cycle 1; BVALID one cycle after the last W handshake.
- BREADY held low: remain in RESP indefinitely; AWREADY stays 0.
- AWLEN=0: single beat; RESP follows the first W handshake.
- rst asserted mid-burst or in RESP: abort, return to IDLE; no B response is issued for the aborted burst.

Optional Feature:
- Macro: AXI_WLAST_CHECK_EN.
- Defined: a WLAST mismatch sets err. Mismatch = WLAST=1 before the final beat, or WLAST=0 on the final beat. On early WLAST, DATA exits at that beat; BRESP=10 and later beats are not written. All beats up to and including the early-WLAST beat are still written.
- Undefined: WLAST is ignored; the burst ends solely on the AWLEN count.

Decomposition:
- Shared package axi_pkg: state enum (IDLE/DATA/RESP), BRESP constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, BURST_FIXED/BURST_INCR encodings, default widths.
- Sub-module: axi_wr_addr_gen. Holds cur_addr and the beat counter; inputs load/step/burst type; outputs mem_addr and last_beat.

Test Plan:
- Single beat: AWID=8'h15, AWADDR=32'h0000_0100, AWLEN=0, WSTRB=4'hF, WDATA=32'hDEAD_BEEF, BREADY=1 -> mem_web=4'h0 and mem_addr=30'h40 for 1 cycle; BVALID 1 cycle later with BID=8'h15, BRESP=00.
- INCR burst: AWADDR=32'h0000_0FF8, AWLEN=3, WVALID toggling every other cycle -> writes to word addresses 3FE, 3FF, 400, 401 only on handshake cycles; BVALID after the 4th beat.
- FIXED burst: AWBURST=00, AWLEN=2 -> all 3 writes hit the same mem_addr. Address wrap: INCR from AWADDR=32'hFFFF_FFFC with AWLEN=1 -> mem_addr 3FFFFFFF then 0.
- Backpressure: BREADY=0 for 5 cycles -> BVALID/BID/BRESP stable; AWREADY=0 with AWVALID=1 during the stall; AW accepted in the first IDLE cycle after the B handshake.
- Errors: AWSIZE=1 -> no mem_web asserted, BRESP=10. With AXI_WLAST_CHECK_EN, AWLEN=3 and WLAST on beat 2 -> beats 1–2 written, BRESP=10.
- Reset mid-burst: rst high after beat 2 of 4 -> next cycle IDLE, BVALID=0, AWREADY=1 after rst drops; no stray B.
